// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared constants and types for the calculator input unit.
//                Default BCD entry geometry, minus-marker nibble, result
//                width and the converter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

    // Digits in the keypad entry word and derived BCD bus width
    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    // Width of the sign-magnitude result magnitude
    localparam int OUT_W      = 32;

    // Nibble value that the keypad uses to mark a negative entry
    localparam logic [3:0] MINUS_CODE = 4'hE;

    // Converter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/bcd_mac10.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mac10
//  Description : Single decimal accumulate step, acc_out = acc_in*10 + digit.
//                The multiply by ten is built from two shifts and an add so
//                one narrow adder chain replaces a constant-multiply tree.
//  Ports       : acc_in  [OUT_W-1:0] running accumulator
//                digit   [3:0]       digit value (raw nibble, 0..15)
//                acc_out [OUT_W-1:0] accumulator after this step
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mac10
    import calc_pkg::*;
#(
    parameter int OUT_W = calc_pkg::OUT_W
) (
    input  logic [OUT_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [OUT_W-1:0] acc_out
);

    logic [OUT_W-1:0] w_times10;
    logic [OUT_W-1:0] w_digit_ext;

    // acc*10 = acc*8 + acc*2
    assign w_times10   = (acc_in << 3) + (acc_in << 1);
    assign w_digit_ext = {{(OUT_W-4){1'b0}}, digit};
    assign acc_out     = w_times10 + w_digit_ext;

endmodule : bcd_mac10
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seq_converter
//  Description : Sequential BCD-entry to sign-magnitude converter. Latches the
//                keypad entry word on start, then walks it MSB-first one digit
//                per clock through a single x10+digit step. The first minus
//                marker seen sets the sign and discards everything above it.
//  Ports       : clk        system clock, rising edge
//                reset      asynchronous active-high reset
//                start      conversion request, honoured in IDLE or DONE
//                bcd        entry word, digit N-1 in the top nibble
//                busy       high while digits are scanned
//                done       one-cycle pulse, results valid
//                binary_sm  result magnitude, held until next accepted start
//                neg        result sign, held with binary_sm
//                err        a nibble above 9 was used as a digit value
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seq_converter
    import calc_pkg::*;
#(
    parameter int         NUM_DIGITS = calc_pkg::NUM_DIGITS,
    parameter int         OUT_W      = calc_pkg::OUT_W,
    parameter logic [3:0] MINUS_CODE = calc_pkg::MINUS_CODE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_W-1:0]        binary_sm,
    output logic                    neg,
    output logic                    err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(NUM_DIGITS - 1);

    state_t                  r_state;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [IDX_W-1:0]        r_idx;
    logic [OUT_W-1:0]        r_acc;
    logic                    r_neg_acc;
    logic                    r_err_acc;
    logic                    r_seen_marker;

    logic [3:0]              w_digit;
    logic                    w_is_marker;
    logic                    w_last;
    logic [OUT_W-1:0]        w_mac_out;
    logic [OUT_W-1:0]        w_acc_next;
    logic                    w_neg_next;
    logic                    w_err_next;

    // Current digit selected by the scan index
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_shadow[4*i +: 4];
            end
        end
    end

    // Only the first marker is special; later 0xE nibbles are plain values
    assign w_is_marker = (w_digit == MINUS_CODE) && !r_seen_marker;
    assign w_last      = (r_idx == '0);

    bcd_mac10 #(
        .OUT_W (OUT_W)
    ) u_mac (
        .acc_in  (r_acc),
        .digit   (w_digit),
        .acc_out (w_mac_out)
    );

    // A marker restarts the magnitude; a marker in the units position leaves
    // nothing after it, so the result is a positive zero.
    assign w_acc_next = w_is_marker ? '0 : w_mac_out;
    assign w_neg_next = w_is_marker ? !w_last : r_neg_acc;
    assign w_err_next = r_err_acc | (!w_is_marker && (w_digit > 4'd9));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_shadow      <= '0;
            r_idx         <= '0;
            r_acc         <= '0;
            r_neg_acc     <= 1'b0;
            r_err_acc     <= 1'b0;
            r_seen_marker <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            binary_sm     <= '0;
            neg           <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Accept: capture the word and clear result and
                        // working state together.
                        r_state       <= SCAN;
                        r_shadow      <= bcd;
                        r_idx         <= c_idx_top;
                        r_acc         <= '0;
                        r_neg_acc     <= 1'b0;
                        r_err_acc     <= 1'b0;
                        r_seen_marker <= 1'b0;
                        busy          <= 1'b1;
                        binary_sm     <= '0;
                        neg           <= 1'b0;
                        err           <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                SCAN: begin
                    r_acc         <= w_acc_next;
                    r_neg_acc     <= w_neg_next;
                    r_err_acc     <= w_err_next;
                    r_seen_marker <= r_seen_marker | w_is_marker;
                    r_idx         <= r_idx - IDX_W'(1);
                    if (w_last) begin
                        // Results come straight from the final step so they
                        // are valid in the same cycle as the done pulse.
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        binary_sm <= w_acc_next;
                        neg       <= w_neg_next;
                        err       <= w_err_next;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule : bcd_seq_converter
`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seq_converter
//  Description : Directed self-checking bench for bcd_seq_converter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_seq_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] bcd;
    logic        busy;
    logic        done;
    logic [31:0] binary_sm;
    logic        neg;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_seq_converter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd       (bcd),
        .busy      (busy),
        .done      (done),
        .binary_sm (binary_sm),
        .neg       (neg),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start at a negedge; returns at the cycle-1 sample point
    task automatic pulse_start(input logic [23:0] v);
        bcd   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the cycle-1 sample point; reports the cycle number in which
    // done was seen, or -1 if it never came within the budget.
    task automatic wait_done(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 1;
        while (!seen && cyc < 30) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bcd   = 24'h0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, neg, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/neg/err=%b expected 0000", {busy, done, neg, err});
        end
        checks++;
        if (binary_sm !== 32'd0) begin
            errors++;
            $display("FAIL reset_mag: got %0d expected 0", binary_sm);
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_latency();
        int busy_bad;
        busy_bad = 0;
        pulse_start(24'h123456);
        // cycles 1..6: busy high, no done
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL latency_busy: got %0d bad busy cycles expected 0", busy_bad);
        end
        @(negedge clk); // cycle 7
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latency_done: got done/busy=%b%b expected 10", done, busy);
        end
        checks++;
        if (binary_sm !== 32'd123456 || neg !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL conv_123456: got %0d neg=%b err=%b expected 123456 0 0", binary_sm, neg, err);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || binary_sm !== 32'd123456) begin
            errors++;
            $display("FAIL result_hold: got done=%b mag=%0d expected 0 123456", done, binary_sm);
        end
    endtask

    // Directed conversion vectors: word, magnitude, sign, error
    task automatic test_vectors();
        logic [23:0] v_bcd [8];
        logic [31:0] v_mag [8];
        logic        v_neg [8];
        logic        v_err [8];
        int          cyc;
        v_bcd[0] = 24'hE00042; v_mag[0] = 32'd42;     v_neg[0] = 1'b1; v_err[0] = 1'b0;
        v_bcd[1] = 24'h12E305; v_mag[1] = 32'd305;    v_neg[1] = 1'b1; v_err[1] = 1'b0;
        v_bcd[2] = 24'h12345E; v_mag[2] = 32'd0;      v_neg[2] = 1'b0; v_err[2] = 1'b0;
        v_bcd[3] = 24'h999999; v_mag[3] = 32'd999999; v_neg[3] = 1'b0; v_err[3] = 1'b0;
        v_bcd[4] = 24'hE1E000; v_mag[4] = 32'd24000;  v_neg[4] = 1'b1; v_err[4] = 1'b1;
        v_bcd[5] = 24'h0000A1; v_mag[5] = 32'd101;    v_neg[5] = 1'b0; v_err[5] = 1'b1;
        v_bcd[6] = 24'hEE0001; v_mag[6] = 32'd140001; v_neg[6] = 1'b1; v_err[6] = 1'b1;
        v_bcd[7] = 24'hFFFFFF; v_mag[7] = 32'd1666665; v_neg[7] = 1'b0; v_err[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pulse_start(v_bcd[i]);
            wait_done(cyc);
            checks++;
            if (cyc != 7) begin
                errors++;
                $display("FAIL vec%0d_latency: got done at cycle %0d expected 7", i, cyc);
            end
            checks++;
            if (binary_sm !== v_mag[i] || neg !== v_neg[i] || err !== v_err[i]) begin
                errors++;
                $display("FAIL vec%0d_%h: got %0d neg=%b err=%b expected %0d neg=%b err=%b",
                         i, v_bcd[i], binary_sm, neg, err, v_mag[i], v_neg[i], v_err[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_shadow();
        int cyc;
        pulse_start(24'h000007);
        bcd = 24'h888888; // changes during scan must not matter
        wait_done(cyc);
        checks++;
        if (cyc != 7 || binary_sm !== 32'd7) begin
            errors++;
            $display("FAIL shadow: got cycle %0d mag %0d expected 7 7", cyc, binary_sm);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dpos [3];
        int ndone;
        int badval;
        ndone  = 0;
        badval = 0;
        bcd    = 24'h000007;
        start  = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (ndone < 3) dpos[ndone] = c;
                ndone++;
                if (binary_sm !== 32'd7) badval++;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses expected 3", ndone);
        end else begin
            checks++;
            if (dpos[0] != 7 || dpos[1] != 14 || dpos[2] != 21) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d %0d %0d expected 7 14 21", dpos[0], dpos[1], dpos[2]);
            end
        end
        checks++;
        if (badval != 0) begin
            errors++;
            $display("FAIL b2b_value: got %0d wrong magnitudes expected 0", badval);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midscan();
        int ndone;
        int cyc;
        ndone = 0;
        pulse_start(24'h654321);
        @(negedge clk);
        @(negedge clk); // cycle 3
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, neg, err} !== 4'b0000 || binary_sm !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got busy/done/neg/err=%b mag=%0d expected 0000 0",
                     {busy, done, neg, err}, binary_sm);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL aborted_no_done: got %0d active cycles expected 0", ndone);
        end
        pulse_start(24'h000321);
        wait_done(cyc);
        checks++;
        if (cyc != 7 || binary_sm !== 32'd321 || neg !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_conv: got cycle %0d mag %0d neg=%b err=%b expected 7 321 0 0",
                     cyc, binary_sm, neg, err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_shadow();
        test_back_to_back();
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_seq_converter
`default_nettype wire
